// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Scans the 8:1 dataflow mux one channel at a time. After each select change
//   it waits SETTLE_CYCLES cycles, then samples mux_y into a shadow word. When
//   every channel has been captured, the word is published on data_out together
//   with a one-cycle done pulse.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   scan request, honoured only while idle
//   mux_y     in   mux output for the current select
//   sel       out  mux select {s2,s1,s0}
//   busy      out  scan in progress
//   done      out  one-cycle pulse, data_out valid from this cycle
//   data_out  out  last completed scan, bit i = y sampled with sel==i
//   parity    out  XOR of data_out (only when SCAN_PARITY_EN is defined)
//
// Build option: define SCAN_PARITY_EN to add the parity port and its register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start
// S_SETTLE | select just changed, counting down the settle time
// S_SAMPLE | capture mux_y for the current select, then advance
// S_DONE   | publish shadow word, pulse done, return select to 0

module mux_scan_sequencer #(
   parameter int SEL_W         = 3,
   parameter int NUM_CH        = 8,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mux_y,
   output logic [SEL_W-1:0]  sel,
   output logic              busy,
   output logic              done,
   output logic [NUM_CH-1:0] data_out
`ifdef SCAN_PARITY_EN
   ,
   output logic              parity
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES);
   localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_CH - 1);
   // With no settle time a new channel goes straight to sampling.
   localparam state_t           CH_ENTRY    = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        cnt;
   logic [NUM_CH-1:0] shadow;
   logic              last_ch;

   assign last_ch = (sel == LAST_SEL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = CH_ENTRY;
         // cnt<=1 rather than ==1 so a corrupted zero count cannot stall the scan.
         S_SETTLE: if (cnt <= 4'd1) state_nxt = S_SAMPLE;
         S_SAMPLE: state_nxt = last_ch ? S_DONE : CH_ENTRY;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_out <= '0;
         shadow   <= '0;
         cnt      <= '0;
`ifdef SCAN_PARITY_EN
         parity   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  shadow <= '0;
                  sel    <= '0;
                  cnt    <= SETTLE_INIT;
                  busy   <= 1'b1;
               end
            end
            S_SETTLE: begin
               cnt <= cnt - 4'd1;
            end
            S_SAMPLE: begin
               shadow[sel] <= mux_y;
               if (!last_ch) begin
                  sel <= sel + SEL_W'(1);
                  cnt <= SETTLE_INIT;
               end
            end
            S_DONE: begin
               // The final sample landed in shadow on the previous edge.
               data_out <= shadow;
               done     <= 1'b1;
               busy     <= 1'b0;
               sel      <= '0;
`ifdef SCAN_PARITY_EN
               parity   <= ^shadow;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
module tb_mux_scan_sequencer;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start0, start1;
   logic [7:0] d0, d1;
   logic       y0, y1;
   logic [2:0] sel0, sel1;
   logic       busy0, busy1, done0, done1;
   logic [7:0] data_out0, data_out1;
`ifdef SCAN_PARITY_EN
   logic       parity0, parity1;
`endif

   int   cyc;
   int   n_vec;
   int   n_err;
   exp_t q0[$];
   exp_t q1[$];

   assign y0 = d0[sel0];
   assign y1 = d1[sel1];

   mux_scan_sequencer #(.SEL_W(3), .NUM_CH(8), .SETTLE_CYCLES(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .mux_y(y0),
      .sel(sel0), .busy(busy0), .done(done0), .data_out(data_out0)
`ifdef SCAN_PARITY_EN
      , .parity(parity0)
`endif
   );

   mux_scan_sequencer #(.SEL_W(3), .NUM_CH(8), .SETTLE_CYCLES(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .mux_y(y1),
      .sel(sel1), .busy(busy1), .done(done1), .data_out(data_out1)
`ifdef SCAN_PARITY_EN
      , .parity(parity1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_vec = n_vec + 1;
      if (act !== req) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard monitor: every done pulse must match the oldest expected scan.
   always @(negedge clk) begin
      exp_t e;
      if (done0) begin
         n_vec = n_vec + 1;
         if (q0.size() == 0) begin
            n_err = n_err + 1;
            $display("FAIL done0_unexpected: done at cycle %0d data %h, none expected", cyc, data_out0);
         end else begin
            e = q0.pop_front();
            if (data_out0 !== e.data || cyc != e.cyc) begin
               n_err = n_err + 1;
               $display("FAIL scan0: got data %h at cycle %0d, expected %h at cycle %0d",
                        data_out0, cyc, e.data, e.cyc);
            end
         end
      end
      if (done1) begin
         n_vec = n_vec + 1;
         if (q1.size() == 0) begin
            n_err = n_err + 1;
            $display("FAIL done1_unexpected: done at cycle %0d data %h, none expected", cyc, data_out1);
         end else begin
            e = q1.pop_front();
            if (data_out1 !== e.data || cyc != e.cyc) begin
               n_err = n_err + 1;
               $display("FAIL scan1: got data %h at cycle %0d, expected %h at cycle %0d",
                        data_out1, cyc, e.data, e.cyc);
            end
`ifdef SCAN_PARITY_EN
            n_vec = n_vec + 1;
            if (parity1 !== ^e.data) begin
               n_err = n_err + 1;
               $display("FAIL parity1: got %b expected %b", parity1, ^e.data);
            end
`endif
         end
      end
   end

   initial begin
      int c;
      cyc    = 0;
      n_vec  = 0;
      n_err  = 0;
      rst_n  = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      d0     = 8'h00;
      d1     = 8'h00;
      #1 rst_n = 1'b0;
      tick(2);

      // T1 reset state
      check("rst_sel", {5'd0, sel0}, 8'h00);
      check("rst_busy", {7'd0, busy0}, 8'h00);
      check("rst_done", {7'd0, done0}, 8'h00);
      check("rst_data", data_out0, 8'h00);
      rst_n = 1'b1;
      tick(5);
      check("idle_sel", {5'd0, sel0}, 8'h00);
      check("idle_busy", {7'd0, busy0}, 8'h00);
      check("idle_data", data_out0, 8'h00);

      // T2 basic scan, select stepping with 2 cycles per channel
      d0 = 8'h01;
      start0 = 1'b1;
      q0.push_back('{data: 8'h01, cyc: cyc + 18});
      tick(1);
      start0 = 1'b0;
      for (int m = 0; m < 16; m++) begin
         check($sformatf("sel_step%0d", m), {5'd0, sel0}, 8'(m / 2));
         check($sformatf("busy_step%0d", m), {7'd0, busy0}, 8'h01);
         tick(1);
      end
      tick(2);
      check("t2_sel_back", {5'd0, sel0}, 8'h00);
      check("t2_busy_low", {7'd0, busy0}, 8'h00);

      // T3 back-to-back scans with start held high
      d0 = 8'hA5;
      c = cyc;
      start0 = 1'b1;
      q0.push_back('{data: 8'hA5, cyc: c + 18});
      q0.push_back('{data: 8'h3C, cyc: c + 36});
      tick(18);
      check("t3_gap_busy", {7'd0, busy0}, 8'h00);
      d0 = 8'h3C;
      tick(1);
      check("t3_retrig_busy", {7'd0, busy0}, 8'h01);
      check("t3_hold_data", data_out0, 8'hA5);
      start0 = 1'b0;
      tick(19);
      check("t3_final_data", data_out0, 8'h3C);

      // T4 start pulses while busy are ignored
      d0 = 8'h96;
      c = cyc;
      start0 = 1'b1;
      q0.push_back('{data: 8'h96, cyc: c + 18});
      tick(1);
      start0 = 1'b0;
      tick(2);
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
      tick(6);
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
      check("t4_hold_data", data_out0, 8'h3C);
      tick(20);
      check("t4_no_requeue", {7'd0, busy0}, 8'h00);
      check("t4_data", data_out0, 8'h96);

      // T5 reset in the middle of a scan
      d0 = 8'hFF;
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
      tick(8);
      rst_n = 1'b0;
      #1;
      check("t5_rst_data", data_out0, 8'h00);
      check("t5_rst_sel", {5'd0, sel0}, 8'h00);
      check("t5_rst_busy", {7'd0, busy0}, 8'h00);
      tick(1);
      rst_n = 1'b1;
      tick(20);
      check("t5_after_data", data_out0, 8'h00);
      start0 = 1'b1;
      q0.push_back('{data: 8'hFF, cyc: cyc + 18});
      tick(1);
      start0 = 1'b0;
      tick(20);
      check("t5_rescan_data", data_out0, 8'hFF);

      // T6 zero settle time
      d1 = 8'h5A;
      start1 = 1'b1;
      q1.push_back('{data: 8'h5A, cyc: cyc + 10});
      tick(1);
      start1 = 1'b0;
      tick(12);
      d1 = 8'h5B;
      start1 = 1'b1;
      q1.push_back('{data: 8'h5B, cyc: cyc + 10});
      tick(1);
      start1 = 1'b0;
      tick(12);
      check("t6_data", data_out1, 8'h5B);

      check("q0_drained", 8'(q0.size()), 8'h00);
      check("q1_drained", 8'(q1.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
